// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants and helpers shared by the scanout path.
package vga_pkg;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // Sync windows are half-open: [start, end)
    localparam int HS_START_D = H_ACTIVE_D + H_FP_D;
    localparam int HS_END_D   = H_ACTIVE_D + H_FP_D + H_SYNC_D;
    localparam int VS_START_D = V_ACTIVE_D + V_FP_D;
    localparam int VS_END_D   = V_ACTIVE_D + V_FP_D + V_SYNC_D;

    localparam int CNT_W = 11;

    // True when val lies in the half-open window [lo, hi)
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input int lo,
                                       input int hi);
        return (int'(val) >= lo) && (int'(val) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-enable divider plus horizontal/vertical scan counters and raw decodes.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_D,
    parameter int H_FP     = H_FP_D,
    parameter int H_SYNC   = H_SYNC_D,
    parameter int H_BP     = H_BP_D,
    parameter int V_ACTIVE = V_ACTIVE_D,
    parameter int V_FP     = V_FP_D,
    parameter int V_SYNC   = V_SYNC_D,
    parameter int V_BP     = V_BP_D
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_visible,
    output logic             o_hs_raw,
    output logic             o_vs_raw,
    output logic             o_frame_wrap
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);

    logic             r_pix_en;
    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (r_hcount == H_LAST);
    assign w_v_last = (r_vcount == V_LAST);

    // Divide-by-2 pixel enable; counters step once per pixel and wrap at their totals
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pix_en <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (w_h_last) begin
                    r_hcount <= '0;
                    if (w_v_last) begin
                        r_vcount <= '0;
                    end else begin
                        r_vcount <= r_vcount + 1'b1;
                    end
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                end
            end
        end
    end

    assign o_pix_en     = r_pix_en;
    assign o_hcount     = r_hcount;
    assign o_vcount     = r_vcount;
    assign o_visible    = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign o_hs_raw     = in_window(r_hcount, HS_START, HS_END);
    assign o_vs_raw     = in_window(r_vcount, VS_START, VS_END);
    assign o_frame_wrap = w_h_last && w_v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: frame RAM read addressing, 1bpp colour expansion and registered DAC outputs.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_D,
    parameter int          H_FP     = H_FP_D,
    parameter int          H_SYNC   = H_SYNC_D,
    parameter int          H_BP     = H_BP_D,
    parameter int          V_ACTIVE = V_ACTIVE_D,
    parameter int          V_FP     = V_FP_D,
    parameter int          V_SYNC   = V_SYNC_D,
    parameter int          V_BP     = V_BP_D,
    parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] rd_x,
    output logic [10:0] rd_y,
    output logic        rd_en,
    input  logic        rd_data,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);

    logic             w_pix_en;
    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_visible;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_frame_wrap;
    logic [23:0]      w_rgb;

    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic [23:0]      r_rgb;
    logic             r_vga_clk;
    logic             r_frame_start;

    vga_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_pix_en     (w_pix_en),
        .o_hcount     (w_hcount),
        .o_vcount     (w_vcount),
        .o_visible    (w_visible),
        .o_hs_raw     (w_hs_raw),
        .o_vs_raw     (w_vs_raw),
        .o_frame_wrap (w_frame_wrap)
    );

    assign rd_x  = w_hcount;
    assign rd_y  = w_vcount;
    assign rd_en = w_visible;

    // Colour select; rd_data is only looked at when visible so blanking never leaks X or stale colour
    always_comb begin
        w_rgb = 24'h000000;
        if (w_visible) begin
            if (rd_data) begin
                w_rgb = FG_RGB;
            end else begin
                w_rgb = BG_RGB;
            end
        end
    end

    // Output register updates on pixel enable; DAC clock and frame strobe run every clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= 24'h000000;
            r_vga_clk     <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_vga_clk     <= ~w_pix_en;
            r_frame_start <= w_pix_en & w_frame_wrap;
            if (w_pix_en) begin
                r_hs      <= ~w_hs_raw;
                r_vs      <= ~w_vs_raw;
                r_blank_n <= w_visible;
                r_rgb     <= w_rgb;
            end
        end
    end

    assign VGA_R       = r_rgb[23:16];
    assign VGA_G       = r_rgb[15:8];
    assign VGA_B       = r_rgb[7:0];
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = r_vga_clk;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout using a shrunken raster so full frames fit in a short run.
module tb_vga_scanout;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HSW = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VSW = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 15
    localparam int VT = VA + VF + VSW + VB;   // 8
    localparam int FRAME_CLK = 2 * HT * VT;   // 240
    localparam logic [23:0] FG = 24'hA5C30F;
    localparam logic [23:0] BG = 24'h123456;

    logic        clk;
    logic        rst_n;
    logic [10:0] rd_x, rd_y;
    logic        rd_en;
    logic        rd_data;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
    logic        frame_start;

    int n_cmp = 0;
    int n_fail = 0;
    int mode = 0;      // 0: all ones, 1: checkerboard, 2: checkerboard with X when not reading
    int e;             // clk edges since reset release

    vga_scanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HSW), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VSW), .V_BP (VB),
        .FG_RGB (FG), .BG_RGB (BG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .VGA_CLK     (VGA_CLK),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame RAM with one clk read latency
    always @(posedge clk) begin
        if (mode == 2 && !rd_en) rd_data <= 1'bx;
        else if (mode == 0)      rd_data <= 1'b1;
        else                     rd_data <= rd_x[0] ^ rd_y[0];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) e <= 0;
        else        e <= e + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, e);
        end
    endtask

    function automatic bit ram_bit(input int x, input int y);
        if (mode == 0) return 1'b1;
        return bit'((x ^ y) & 1);
    endfunction

    // Expected pin state after e clk edges since release, from raster arithmetic
    function automatic logic [52:0] model(input int ee);
        int adv, h, v, ap, hp, vp;
        logic [10:0] x, y;
        logic en, hs, vs, bn, vclk, fs;
        logic [23:0] rgb;
        adv = ee / 2;
        h = adv % HT;
        v = (adv / HT) % VT;
        x = 11'(h);
        y = 11'(v);
        en = (h < HA) && (v < VA);
        hs = 1'b1; vs = 1'b1; bn = 1'b0; rgb = 24'h0;
        if (ee >= 2) begin
            ap = ee / 2 - 1;
            hp = ap % HT;
            vp = (ap / HT) % VT;
            hs = !((hp >= HA + HF) && (hp < HA + HF + HSW));
            vs = !((vp >= VA + VF) && (vp < VA + VF + VSW));
            bn = (hp < HA) && (vp < VA);
            if (bn) rgb = ram_bit(hp, vp) ? FG : BG;
        end
        vclk = (ee % 2) == 1;
        fs = (ee >= 2) && ((ee % 2) == 0) && (((ee / 2) % (HT * VT)) == 0);
        return {x, y, en, rgb, hs, vs, bn, 1'b0, vclk, fs};
    endfunction

    // Every-cycle comparison of all pins against the model
    initial begin
        forever begin
            @(negedge clk);
            check("pins", 64'({rd_x, rd_y, rd_en, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
                               VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, frame_start}), 64'(model(e)));
        end
    end

    // Sync/blank interval measurements
    initial begin
        logic p_hs, p_vs, p_bn;
        int hf_e, vf_e, br_e, blank_cnt, lines;
        bit hf_ok, vf_ok, br_ok;
        p_hs = 1; p_vs = 1; p_bn = 0; hf_ok = 0; vf_ok = 0; br_ok = 0;
        hf_e = 0; vf_e = 0; br_e = 0; blank_cnt = 0; lines = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_hs = 1; p_vs = 1; p_bn = 0; hf_ok = 0; vf_ok = 0; br_ok = 0;
                blank_cnt = 0; lines = 0;
            end else begin
                if (VGA_BLANK_N) blank_cnt++;
                if (VGA_BLANK_N && !p_bn) begin
                    br_e = e; br_ok = 1; lines++;
                end
                if (!VGA_BLANK_N && p_bn && br_ok)
                    check("blank_width", 64'(e - br_e), 64'(2 * HA));
                if (!VGA_HS && p_hs) begin
                    if (hf_ok) check("hs_period", 64'(e - hf_e), 64'(2 * HT));
                    if (br_ok && (e - br_e) < 2 * HT)
                        check("hs_fall_offset", 64'(e - br_e), 64'(2 * (HA + HF)));
                    hf_e = e; hf_ok = 1;
                end
                if (VGA_HS && !p_hs && hf_ok)
                    check("hs_low", 64'(e - hf_e), 64'(2 * HSW));
                if (!VGA_VS && p_vs) begin
                    if (vf_ok) check("vs_period", 64'(e - vf_e), 64'(FRAME_CLK));
                    check("lines_per_frame", 64'(lines), 64'(VA));
                    check("visible_per_frame", 64'(blank_cnt), 64'(2 * HA * VA));
                    vf_e = e; vf_ok = 1; lines = 0; blank_cnt = 0;
                end
                if (VGA_VS && !p_vs && vf_ok)
                    check("vs_low", 64'(e - vf_e), 64'(2 * VSW * HT));
                p_hs = VGA_HS; p_vs = VGA_VS; p_bn = VGA_BLANK_N;
            end
        end
    end

    task automatic wait_fs(output int at_e);
        bit found;
        found = 0;
        at_e = -1;
        for (int k = 0; k < 3 * FRAME_CLK && !found; k++) begin
            @(negedge clk);
            if (frame_start) begin
                at_e = e;
                found = 1;
            end
        end
        if (!found) begin
            n_cmp++; n_fail++;
            $display("FAIL fs_timeout: no frame_start within %0d clk", 3 * FRAME_CLK);
        end
    endtask

    task automatic wait_edge(input int target);
        for (int k = 0; k < 4 * FRAME_CLK && e != target; k++) @(negedge clk);
    endtask

    initial begin
        int a, b;
        bit hit;
        rst_n = 1'b0;
        rd_data = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_pins", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
                                 VGA_CLK, frame_start, rd_en, rd_x, rd_y}),
              64'({1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 22'h0}));

        // Run 1: constant ones
        rst_n = 1'b1;
        @(negedge clk);
        check("no_advance_edge1", 64'(rd_x), 64'd0);
        @(negedge clk);
        check("first_advance_edge2", 64'(rd_x), 64'd1);
        check("fg_first_pixel", 64'({VGA_R, VGA_G, VGA_B}), 64'h00A5C30F);
        wait_fs(a);
        check("first_frame_start", 64'(a), 64'd240);
        wait_fs(b);
        check("fs_interval_1", 64'(b - a), 64'd240);

        // Run 2: checkerboard
        rst_n = 1'b0;
        mode = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_edge(2);
        check("pix00_bg", 64'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 64'h0000000001123456);
        wait_edge(4);
        check("pix10_fg", 64'({VGA_BLANK_N, VGA_R, VGA_G, VGA_B}), 64'h0000000001A5C30F);
        wait_fs(a);
        wait_fs(b);
        check("fs_interval_2", 64'(b - a), 64'd240);

        // Mid-frame asynchronous reset at (4,2), then checkerboard with X outside reads
        hit = 0;
        for (int k = 0; k < 2 * FRAME_CLK && !hit; k++) begin
            @(negedge clk);
            if (rd_x == 11'd4 && rd_y == 11'd2) hit = 1;
        end
        check("reach_4_2", 64'(hit), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mode = 2;
        #1;
        check("async_reset_pins", 64'({VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
                                       VGA_CLK, frame_start, rd_en, rd_x, rd_y}),
              64'({1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 22'h0}));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs(a);
        check("fs_after_midreset", 64'(a), 64'd240);
        wait_fs(b);
        check("fs_interval_3", 64'(b - a), 64'd240);
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
